mux_scan_sequencer: RTL and testbench



---
 rtl/mux_scan_pkg.sv | 13 +
 rtl/mux_scan_next_ch.sv | 33 +++
 rtl/mux_scan_sequencer.sv | 147 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
package mux_scan_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } scan_state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest enabled channel strictly above cur_idx; cur_idx = -1 yields the first channel.
module mux_scan_next_ch
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0]       mask,
    input  logic signed [SEL_W:0]   cur_idx,
    output logic [SEL_W-1:0]        next_sel,
    output logic                    found
);

    logic [NUM_CH-1:0] above;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_above
            localparam logic signed [SEL_W:0] IDX = gi;
            assign above[gi] = mask[gi] && (cur_idx < IDX);
        end
    endgenerate

    // Descending walk so the lowest candidate is the one that sticks.
    always_comb begin
        next_sel = '0;
        found    = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (above[i]) begin
                next_sel = SEL_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans the enabled mux channels in ascending order, dwelling DWELL cycles on each, then reports a sample word.
// Optional continuous rescanning is compiled in with MUX_SCAN_CONT_EN (adds the cont port).
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MUX_SCAN_CONT_EN
    input  logic              cont,
`endif
    input  logic              start,
    input  logic [NUM_CH-1:0] enable_mask,
    input  logic              mux_o,
    output logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] sample,
    output logic              valid,
    output logic              busy
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    scan_state_t       state_reg, state_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [NUM_CH-1:0] mask_reg, mask_next;
    logic [NUM_CH-1:0] shadow_reg, shadow_next;
    logic [NUM_CH-1:0] sample_reg, sample_next;
    logic              valid_reg, valid_next;

    logic [SEL_W-1:0]  first_sel, adv_sel;
    logic              first_found, adv_found;
    logic              cont_req;
    logic              accept;
    logic              dwell_end;

`ifdef MUX_SCAN_CONT_EN
    assign cont_req = cont;
`else
    assign cont_req = 1'b0;
`endif

    mux_scan_next_ch u_first (
        .mask     (enable_mask),
        .cur_idx  ('1),
        .next_sel (first_sel),
        .found    (first_found)
    );

    mux_scan_next_ch u_adv (
        .mask     (mask_reg),
        .cur_idx  ({1'b0, sel_reg}),
        .next_sel (adv_sel),
        .found    (adv_found)
    );

    // The valid cycle still counts as busy, so a start there is ignored.
    assign accept    = start && !valid_reg;
    assign dwell_end = (cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = first_found ? SETTLE : DONE;
            SETTLE:  if (dwell_end && !adv_found) state_next = DONE;
            DONE:    state_next = (cont_req && first_found) ? SETTLE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_next    = sel_reg;
        cnt_next    = cnt_reg;
        mask_next   = mask_reg;
        shadow_next = shadow_reg;
        sample_next = sample_reg;
        valid_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    mask_next = enable_mask;
                    if (first_found) begin
                        sel_next = first_sel;
                        cnt_next = RELOAD;
                    end
                end
            end
            SETTLE: begin
                if (!dwell_end) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else begin
                    shadow_next[sel_reg] = mux_o;
                    if (adv_found) begin
                        sel_next = adv_sel;
                        cnt_next = RELOAD;
                    end
                end
            end
            DONE: begin
                sample_next = shadow_reg & mask_reg;
                valid_next  = 1'b1;
                if (cont_req) begin
                    mask_next = enable_mask;
                    if (first_found) begin
                        sel_next = first_sel;
                        cnt_next = RELOAD;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg    <= '0;
            cnt_reg    <= '0;
            mask_reg   <= '0;
            shadow_reg <= '0;
            sample_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            sel_reg    <= sel_next;
            cnt_reg    <= cnt_next;
            mask_reg   <= mask_next;
            shadow_reg <= shadow_next;
            sample_reg <= sample_next;
            valid_reg  <= valid_next;
        end
    end

    assign sel    = sel_reg;
    assign sample = sample_reg;
    assign valid  = valid_reg;
    assign busy   = (state_reg != IDLE) || valid_reg;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer (DWELL=4); continuous-mode scenario runs when MUX_SCAN_CONT_EN is defined.
module tb_mux_scan_sequencer;

    localparam int DWELL = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] enable_mask;
    logic       mux_o;
    logic [1:0] sel;
    logic [3:0] sample;
    logic       valid;
    logic       busy;
    logic       cont;
    logic [3:0] ch_in;

    int cyc = 0;
    int compare_cnt = 0;
    int mismatch_cnt = 0;

    typedef struct {
        logic [3:0] smp;
        int         vcyc;
    } exp_t;
    exp_t exp_q[$];

    mux_scan_sequencer #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef MUX_SCAN_CONT_EN
        .cont        (cont),
`endif
        .start       (start),
        .enable_mask (enable_mask),
        .mux_o       (mux_o),
        .sel         (sel),
        .sample      (sample),
        .valid       (valid),
        .busy        (busy)
    );

    // Structural mux stand-in: each channel is a constant bit of ch_in.
    assign mux_o = ch_in[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compare_cnt++;
        if (obs !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sample", {28'd0, sample}, {28'd0, e.smp});
                check_eq("valid_cycle", cyc, e.vcyc);
                check_eq("busy_at_valid", {31'd0, busy}, 32'd1);
                $display("txn: sample=%b cycle=%0d expected_sample=%b expected_cycle=%0d",
                         sample, cyc, e.smp, e.vcyc);
            end
        end
    end

    task automatic wait_idle(input string tag, input int exp_tail);
        int w;
        w = 0;
        while (busy && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (busy) check_eq({tag, "_idle_timeout"}, 32'd1, 32'd0);
        else if (exp_tail >= 0) check_eq({tag, "_busy_tail"}, w, exp_tail);
    endtask

    task automatic run_scan(input logic [3:0] m, input logic [3:0] ch, input bit disturb);
        logic [1:0] prev_sel;
        int n;
        @(negedge clk);
        prev_sel    = sel;
        n           = $countones(m);
        ch_in       = ch;
        enable_mask = m;
        start       = 1'b1;
        exp_q.push_back('{smp: m & ch, vcyc: cyc + 1 + n * DWELL + 1});
        @(negedge clk);
        start = 1'b0;
        if (m == 4'b0000) check_eq("sel_hold", {30'd0, sel}, {30'd0, prev_sel});
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                for (int d = 0; d < DWELL; d++) begin
                    check_eq("sel_step", {30'd0, sel}, i);
                    check_eq("busy_scan", {31'd0, busy}, 32'd1);
                    if (disturb && d == 1) begin
                        start       = 1'b1;
                        enable_mask = ~m;
                    end else begin
                        start = 1'b0;
                    end
                    @(negedge clk);
                end
            end
        end
        start = 1'b0;
        // DONE cycle then valid cycle remain busy.
        wait_idle("scan", 2);
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        enable_mask = 4'b0000;
        ch_in       = 4'b0000;
        cont        = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sel", {30'd0, sel}, 32'd0);
        check_eq("rst_sample", {28'd0, sample}, 32'd0);
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        run_scan(4'b1111, 4'b1101, 1'b0);
        run_scan(4'b1010, 4'b1010, 1'b0);
        run_scan(4'b0000, 4'b1111, 1'b0);
        run_scan(4'b0110, 4'b1111, 1'b1);

        // Abort during channel 2 dwell.
        @(negedge clk);
        ch_in       = 4'b1111;
        enable_mask = 4'b1111;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 * DWELL + 1) @(negedge clk);
        check_eq("sel_pre_rst", {30'd0, sel}, 32'd2);
        rst_n = 1'b0;
        #1;
        check_eq("abort_sel", {30'd0, sel}, 32'd0);
        check_eq("abort_sample", {28'd0, sample}, 32'd0);
        check_eq("abort_valid", {31'd0, valid}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_scan(4'b1111, 4'b0101, 1'b0);
        run_scan(4'b1000, 4'b1000, 1'b0);
        run_scan(4'b0101, 4'b1010, 1'b0);

`ifdef MUX_SCAN_CONT_EN
        begin
            int c;
            @(negedge clk);
            ch_in       = 4'b0001;
            enable_mask = 4'b0001;
            cont        = 1'b1;
            start       = 1'b1;
            c           = cyc;
            for (int k = 1; k <= 3; k++) exp_q.push_back('{smp: 4'b0001, vcyc: c + 1 + 5 * k});
            @(negedge clk);
            start = 1'b0;
            while (cyc < c + 1 + 5 * 2) begin
                check_eq("cont_busy", {31'd0, busy}, 32'd1);
                @(negedge clk);
            end
            cont = 1'b0;
            wait_idle("cont", -1);
        end
`endif

        repeat (3) @(negedge clk);
        check_eq("pending_exp", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
